// File: rtl/flash_strobe_gen.sv
// Strobe generator: conditions run/rate switches and pulses o_enable once every L cycles.
// Optional run-bit debounce is enabled by defining STROBE_DEBOUNCE_EN.
module flash_strobe_gen #(
    parameter int     NB_COUNTER      = 32,
    parameter longint LIMIT_0         = 2**19,
    parameter longint LIMIT_1         = 2**20,
    parameter longint LIMIT_2         = 2**21,
    parameter longint LIMIT_3         = 2**22,
    parameter int     DEBOUNCE_CYCLES = 16
) (
    input  logic       clock,
    input  logic       i_reset,
    input  logic [2:0] i_sw,
    output logic       o_enable,
    output logic       o_running,
    output logic [1:0] o_rate
);

    // Elaboration-time guard on the configuration.
    if (LIMIT_0 < 1 || LIMIT_1 < 1 || LIMIT_2 < 1 || LIMIT_3 < 1 ||
        LIMIT_0 > (64'd1 << NB_COUNTER) || LIMIT_1 > (64'd1 << NB_COUNTER) ||
        LIMIT_2 > (64'd1 << NB_COUNTER) || LIMIT_3 > (64'd1 << NB_COUNTER) ||
        DEBOUNCE_CYCLES < 1) begin : g_bad_cfg
        $error("flash_strobe_gen: illegal LIMIT_k or DEBOUNCE_CYCLES");
    end

    // Limits are widened by one bit so LIMIT = 2**NB_COUNTER still yields an exact L-1.
    localparam logic [NB_COUNTER:0] LIM0 = (NB_COUNTER+1)'(LIMIT_0);
    localparam logic [NB_COUNTER:0] LIM1 = (NB_COUNTER+1)'(LIMIT_1);
    localparam logic [NB_COUNTER:0] LIM2 = (NB_COUNTER+1)'(LIMIT_2);
    localparam logic [NB_COUNTER:0] LIM3 = (NB_COUNTER+1)'(LIMIT_3);
    localparam logic [NB_COUNTER-1:0] LAST0 = NB_COUNTER'(LIM0 - 1'b1);
    localparam logic [NB_COUNTER-1:0] LAST1 = NB_COUNTER'(LIM1 - 1'b1);
    localparam logic [NB_COUNTER-1:0] LAST2 = NB_COUNTER'(LIM2 - 1'b1);
    localparam logic [NB_COUNTER-1:0] LAST3 = NB_COUNTER'(LIM3 - 1'b1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    logic [2:0]            sync1_q, sync2_q;
    logic                  run_s, run_eff;
    logic [1:0]            rate_s;
    state_t                state_q, state_d;
    logic [NB_COUNTER-1:0] cnt_q, cnt_d, last_cnt;
    logic                  enable_q, enable_d;
    logic [1:0]            rate_q, rate_d;

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= i_sw;
            sync2_q <= sync1_q;
        end
    end

    assign run_s  = sync2_q[0];
    assign rate_s = sync2_q[2:1];

`ifdef STROBE_DEBOUNCE_EN
    localparam int NB_DEB = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [NB_DEB-1:0] DEB_LAST = NB_DEB'(DEBOUNCE_CYCLES - 1);

    logic [NB_DEB-1:0] deb_cnt_q, deb_cnt_d;
    logic              run_f_q, run_f_d;

    // Any return of run_s to the accepted value restarts the stability window.
    always_comb begin
        run_f_d   = run_f_q;
        deb_cnt_d = '0;
        if (run_s != run_f_q) begin
            if (deb_cnt_q == DEB_LAST) begin
                run_f_d = run_s;
            end else begin
                deb_cnt_d = deb_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            run_f_q   <= 1'b0;
            deb_cnt_q <= '0;
        end else begin
            run_f_q   <= run_f_d;
            deb_cnt_q <= deb_cnt_d;
        end
    end

    assign run_eff = run_f_q;
`else
    assign run_eff = run_s;
`endif

    // Period in effect follows the latched rate, so mid-period changes wait for the wrap.
    always_comb begin
        last_cnt = LAST0;
        case (rate_q)
            2'd0: last_cnt = LAST0;
            2'd1: last_cnt = LAST1;
            2'd2: last_cnt = LAST2;
            2'd3: last_cnt = LAST3;
            default: last_cnt = LAST0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        enable_d = 1'b0;
        rate_d   = rate_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (run_eff) begin
                    state_d = RUN;
                    rate_d  = rate_s;
                end
            end
            RUN: begin
                if (!run_eff) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == last_cnt) begin
                    cnt_d    = '0;
                    enable_d = 1'b1;
                    rate_d   = rate_s;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            enable_q <= 1'b0;
            rate_q   <= 2'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            enable_q <= enable_d;
            rate_q   <= rate_d;
        end
    end

    assign o_enable  = enable_q;
    assign o_running = (state_q == RUN);
    assign o_rate    = rate_q;

endmodule

// File: tb/tb_flash_strobe_gen.sv
// Directed bench for flash_strobe_gen: per-cycle vector table plus an async-reset sequence.
module tb_flash_strobe_gen;

    logic       clock = 1'b0;
    logic       i_reset;
    logic [2:0] i_sw;
    logic       o_enable;
    logic       o_running;
    logic [1:0] o_rate;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [2:0] sw;
        logic       en;
        logic       run;
        logic [1:0] rate;
    } vec_t;

    vec_t vecs[$];

    flash_strobe_gen #(
        .NB_COUNTER     (8),
        .LIMIT_0        (4),
        .LIMIT_1        (8),
        .LIMIT_2        (1),
        .LIMIT_3        (16),
        .DEBOUNCE_CYCLES(16)
    ) dut (
        .clock    (clock),
        .i_reset  (i_reset),
        .i_sw     (i_sw),
        .o_enable (o_enable),
        .o_running(o_running),
        .o_rate   (o_rate)
    );

    always #5 clock = ~clock;

    function automatic void add(input logic [2:0] sw, input logic en, input logic run,
                                input logic [1:0] rate, input int n);
        vec_t v;
        v.sw   = sw;
        v.en   = en;
        v.run  = run;
        v.rate = rate;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endfunction

    task automatic check(input string name, input int idx, input logic [3:0] exp);
        logic [3:0] act;
        act = {o_enable, o_running, o_rate};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got en/run/rate=%b/%b/%0d, expected %b/%b/%0d",
                     name, idx, act[3], act[2], act[1:0], exp[3], exp[2], exp[1:0]);
        end
    endtask

    // Each vector drives i_sw before an edge and checks outputs 1 time unit after it.
    task automatic run_vectors(input string name);
        for (int i = 0; i < vecs.size(); i++) begin
            i_sw = vecs[i].sw;
            @(posedge clock);
            #1;
            check(name, i, {vecs[i].en, vecs[i].run, vecs[i].rate});
        end
        vecs.delete();
    endtask

    initial begin
        i_reset = 1'b0;
        i_sw    = 3'b000;
        #12;
        check("reset_state", 0, 4'b0000);
        @(posedge clock);
        #1;
        i_reset = 1'b1;

        add(3'b000, 0, 0, 2'd0, 20);
`ifdef STROBE_DEBOUNCE_EN
        add(3'b001, 0, 0, 2'd0, 10);   // 10-cycle glitch is filtered
        add(3'b000, 0, 0, 2'd0, 30);
        add(3'b001, 0, 0, 2'd0, 18);   // 20-cycle pulse: RUN 16 cycles after run_s settles
        add(3'b001, 0, 1, 2'd0, 2);
        add(3'b000, 0, 1, 2'd0, 2);
        add(3'b000, 1, 1, 2'd0, 1);
        run_vectors("debounce");
`else
        add(3'b001, 0, 0, 2'd0, 2);    // run sampled at edge 0, RUN after edge 2
        add(3'b001, 0, 1, 2'd0, 4);
        add(3'b001, 1, 1, 2'd0, 1);    // first strobe after edge 6
        add(3'b001, 0, 1, 2'd0, 3);
        add(3'b001, 1, 1, 2'd0, 1);
        add(3'b011, 0, 1, 2'd0, 3);    // rate 1 requested mid-period
        add(3'b011, 1, 1, 2'd1, 1);    // applied at the wrap
        add(3'b011, 0, 1, 2'd1, 7);
        add(3'b011, 1, 1, 2'd1, 1);
        add(3'b011, 0, 1, 2'd1, 7);
        add(3'b011, 1, 1, 2'd1, 1);
        add(3'b101, 0, 1, 2'd1, 7);    // rate 2 (L=1) takes effect at next wrap
        add(3'b101, 1, 1, 2'd2, 1);
        add(3'b101, 1, 1, 2'd2, 5);
        add(3'b100, 1, 1, 2'd2, 2);    // run cleared: 2-cycle latency
        add(3'b100, 0, 0, 2'd2, 3);
        add(3'b001, 0, 0, 2'd2, 2);
        add(3'b001, 0, 1, 2'd0, 2);
        add(3'b000, 0, 1, 2'd0, 2);    // run_s falls on the cnt==3 edge
        add(3'b000, 0, 0, 2'd0, 3);    // IDLE wins, no strobe
        add(3'b001, 0, 0, 2'd0, 2);
        add(3'b001, 0, 1, 2'd0, 4);    // restart proves cnt was cleared
        add(3'b001, 1, 1, 2'd0, 1);
        add(3'b001, 0, 1, 2'd0, 2);
        run_vectors("main");

        // Asynchronous reset in the middle of a period.
        #3;
        i_reset = 1'b0;
        #1;
        check("async_reset_now", 0, 4'b0000);
        @(posedge clock);
        #1;
        check("async_reset_hold", 0, 4'b0000);
        i_reset = 1'b1;

        add(3'b001, 0, 0, 2'd0, 2);
        add(3'b001, 0, 1, 2'd0, 4);
        add(3'b001, 1, 1, 2'd0, 1);
        run_vectors("after_reset");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/flash_strobe_gen.md
# flash_strobe_gen

Rate generator that drives the `i_enable` input of the LED flasher. It conditions the board run/rate switches and emits a one-cycle enable strobe every L clock cycles. L is chosen from four parameterised period limits. The block sits between the switch pins and the flasher, so the flasher toggles its LEDs once per strobe.

## Interface
Parameters:
- NB_COUNTER, 32, width of the period counter.
- LIMIT_0, 2**19, period in cycles for rate select 0.
- LIMIT_1, 2**20, period in cycles for rate select 1.
- LIMIT_2, 2**21, period in cycles for rate select 2.
- LIMIT_3, 2**22, period in cycles for rate select 3.
- DEBOUNCE_CYCLES, 16, stability window for run bit; used only with STROBE_DEBOUNCE_EN.

Ports:
- clock  input  1  system clock, all logic on rising edge.
- i_reset  input  1  reset, asynchronous, active-low.
- i_sw  input  3  asynchronous switches: [0] run, [2:1] rate select.
- o_enable  output  1  registered one-cycle strobe to the flasher.
- o_running  output  1  high while the FSM is in RUN.
- o_rate  output  2  rate select currently in effect (latched).

## Operation
- Synchronizer: 2-FF chain on all three i_sw bits, reset to 0. The FSM uses only the second-stage value (run_s, rate_s).
- FSM states:
  - IDLE (reset state): cnt held at 0, o_enable 0.
  - RUN: counting.
- Transitions:
  - IDLE→RUN when run_s=1. On the entry edge: cnt←0, o_rate←rate_s.
  - RUN→IDLE when run_s=0. On that edge: cnt←0, o_enable←0.
- Counting in RUN (L = LIMIT_o_rate):
  - If cnt == L-1: cnt←0, o_enable←1, o_rate←rate_s.
  - Otherwise: cnt←cnt+1, o_enable←0.
- Rate changes mid-period are deferred to the next wrap. The running period is never truncated or stretched.
- L=1: o_enable stays high every cycle in RUN.
- LIMIT values must satisfy 1 ≤ LIMIT_k ≤ 2**NB_COUNTER. The comparison uses the full counter width, with no truncation.
- Run drop coinciding with cnt==L-1: IDLE wins, no strobe is issued.
- Reset values:
  - o_enable 0, o_running 0, o_rate 0.
  - cnt 0, state IDLE, sync FFs 0.
- Reset asserted mid-period clears everything immediately (asynchronous). After release, behaviour restarts from IDLE.

## Timing
- i_sw change sampled at edge k appears at run_s/rate_s after edge k+1. The FSM acts on edge k+2 (2-cycle input latency, no debounce).
- o_running rises with the RUN entry edge E0 and falls with the IDLE entry edge.
- First o_enable high for exactly one cycle after edge E_L, i.e. L edges after E0. Subsequent strobes follow every L cycles with no gap error.
- o_enable is a register output with no combinational path from i_sw.

## Configuration
- STROBE_DEBOUNCE_EN defined:
  - run_s must hold a new value for DEBOUNCE_CYCLES consecutive cycles before the FSM sees it. The debounce counter resets on any toggle.
  - Adds DEBOUNCE_CYCLES cycles of latency on run only. The rate bits are not debounced.
- STROBE_DEBOUNCE_EN undefined: the FSM uses run_s directly. The debounce logic and the DEBOUNCE_CYCLES usage are compiled out.

## Test plan
Bench parameters: LIMIT_0=4, LIMIT_1=8, LIMIT_2=1, LIMIT_3=16, NB_COUNTER=8.
- Reset, i_sw=3'b000 for 20 cycles:
  - o_enable, o_running and o_rate stay 0.
- i_sw=3'b001 at edge k:
  - o_running=1 after edge k+2.
  - o_enable pulses one cycle after edge k+6, then every 4 cycles.
- In RUN rate 0, switch to i_sw=3'b011 mid-period:
  - The current 4-cycle period completes.
  - o_rate becomes 1 at that wrap, and the strobe spacing becomes 8.
- i_sw=3'b101 (rate 2, L=1):
  - o_enable stays high every cycle while running.
  - Clearing run drops o_enable and o_running after 2-cycle latency.
- Drop run timed so run_s falls on the cnt==3 edge:
  - No strobe is issued, and the FSM goes to IDLE with cnt=0.
  - Assert i_reset mid-period in a separate run: all outputs go to 0 asynchronously.
- With STROBE_DEBOUNCE_EN, DEBOUNCE_CYCLES=16:
  - A 10-cycle run glitch produces no RUN entry.
  - A 20-cycle run pulse enters RUN 16 cycles after run_s settles.
